// File: rtl/emif_rd_arbiter.sv
// Two-requester AXI read-path arbiter in front of the EMIF slave port.
// AR requests are granted round-robin into a single registered AR slot,
// tagged with the requester index in ARID[6]; R beats are steered back by
// RID[6]. Per-requester outstanding-burst counters throttle AR acceptance
// and flag responses that arrive for a requester with nothing outstanding.
module emif_rd_arbiter #(
  parameter  int unsigned ADDR_W    = 33,
  parameter  int unsigned MAX_OUTST = 16,
  localparam int unsigned AR_W      = ADDR_W + 25,
  localparam int unsigned R_W       = 323
) (
  input  logic            axi_clk,
  input  logic            axi_reset_n,

  input  logic            s0_arvalid,
  output logic            s0_arready,
  input  logic [5:0]      s0_arid,
  input  logic [AR_W-1:0] s0_ar,
  output logic            s0_rvalid,
  input  logic            s0_rready,
  output logic [5:0]      s0_rid,
  output logic [R_W-1:0]  s0_r,

  input  logic            s1_arvalid,
  output logic            s1_arready,
  input  logic [5:0]      s1_arid,
  input  logic [AR_W-1:0] s1_ar,
  output logic            s1_rvalid,
  input  logic            s1_rready,
  output logic [5:0]      s1_rid,
  output logic [R_W-1:0]  s1_r,

  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [6:0]      m_arid,
  output logic [AR_W-1:0] m_ar,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [6:0]      m_rid,
  input  logic [R_W-1:0]  m_r,

  output logic            rsp_err,
  output logic [7:0]      outst0,
  output logic [7:0]      outst1
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTST);
  localparam int unsigned RLAST_BIT = 258;

  typedef enum logic {
    FAV_S0 = 1'b0,
    FAV_S1 = 1'b1
  } fav_e;

  fav_e rr_fav;

  logic elig0, elig1;
  logic gnt0, gnt1;
  logic slot_free;
  logic acc0, acc1;
  logic r_sel;
  logic rlast_hs;
  logic dec0, dec1;
  logic err0, err1;

  // Eligibility, round-robin grant and AR handshakes
  always_comb begin
    elig0      = s0_arvalid && (outst0 < MAX_CNT);
    elig1      = s1_arvalid && (outst1 < MAX_CNT);
    gnt0       = elig0 && (!elig1 || (rr_fav == FAV_S0));
    gnt1       = elig1 && (!elig0 || (rr_fav == FAV_S1));
    slot_free  = !m_arvalid || m_arready;
    s0_arready = slot_free && gnt0;
    s1_arready = slot_free && gnt1;
    acc0       = s0_arvalid && s0_arready;
    acc1       = s1_arvalid && s1_arready;
  end

  // R channel steering by RID[6] and last-beat bookkeeping
  always_comb begin
    r_sel     = m_rid[6];
    s0_rvalid = m_rvalid && !r_sel;
    s1_rvalid = m_rvalid && r_sel;
    s0_rid    = m_rid[5:0];
    s1_rid    = m_rid[5:0];
    s0_r      = m_r;
    s1_r      = m_r;
    m_rready  = r_sel ? s1_rready : s0_rready;
    rlast_hs  = m_rvalid && m_rready && m_r[RLAST_BIT];
    dec0      = rlast_hs && !r_sel && (outst0 != '0);
    dec1      = rlast_hs && r_sel && (outst1 != '0);
    err0      = rlast_hs && !r_sel && (outst0 == '0);
    err1      = rlast_hs && r_sel && (outst1 == '0);
  end

  // AR holding register: load on accept, drop valid when drained, else hold
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_ar      <= '0;
    end else if (acc0) begin
      m_arvalid <= 1'b1;
      m_arid    <= {1'b0, s0_arid};
      m_ar      <= s0_ar;
    end else if (acc1) begin
      m_arvalid <= 1'b1;
      m_arid    <= {1'b1, s1_arid};
      m_ar      <= s1_ar;
    end else if (m_arready) begin
      m_arvalid <= 1'b0;
    end
  end

  // Round-robin pointer flips to the requester that did not just win
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      rr_fav <= FAV_S0;
    end else if (acc0) begin
      rr_fav <= FAV_S1;
    end else if (acc1) begin
      rr_fav <= FAV_S0;
    end
  end

  // Outstanding-burst counters; simultaneous accept and last beat cancel out
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      outst0 <= '0;
      outst1 <= '0;
    end else begin
      if (acc0 && !dec0) begin
        outst0 <= outst0 + 8'd1;
      end else if (!acc0 && dec0) begin
        outst0 <= outst0 - 8'd1;
      end
      if (acc1 && !dec1) begin
        outst1 <= outst1 + 8'd1;
      end else if (!acc1 && dec1) begin
        outst1 <= outst1 - 8'd1;
      end
    end
  end

  // Sticky flag for a last beat arriving with no burst outstanding
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      rsp_err <= 1'b0;
    end else if (err0 || err1) begin
      rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_emif_rd_arbiter.sv
// Bench for emif_rd_arbiter: directed scenarios followed by randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_emif_rd_arbiter;

  localparam int unsigned ADDR_W    = 33;
  localparam int unsigned MAX_OUTST = 16;
  localparam int unsigned AR_W      = ADDR_W + 25;
  localparam int unsigned R_W       = 323;

  logic            axi_clk;
  logic            axi_reset_n;
  logic            s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [5:0]      s0_arid, s0_rid;
  logic [AR_W-1:0] s0_ar;
  logic [R_W-1:0]  s0_r;
  logic            s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [5:0]      s1_arid, s1_rid;
  logic [AR_W-1:0] s1_ar;
  logic [R_W-1:0]  s1_r;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [6:0]      m_arid, m_rid;
  logic [AR_W-1:0] m_ar;
  logic [R_W-1:0]  m_r;
  logic            rsp_err;
  logic [7:0]      outst0, outst1;

  int total = 0;
  int bad   = 0;

  emif_rd_arbiter #(.ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_arid(s0_arid), .s0_ar(s0_ar),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rid(s0_rid), .s0_r(s0_r),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_arid(s1_arid), .s1_ar(s1_ar),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rid(s1_rid), .s1_r(s1_r),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_ar(m_ar),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_r(m_r),
    .rsp_err(rsp_err), .outst0(outst0), .outst1(outst1)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Reference model: registered AR slot, who-is-favoured, burst counts, error
  bit              mdl_valid;
  logic [6:0]      mdl_id;
  logic [AR_W-1:0] mdl_ar;
  int              mdl_fav;
  int              mdl_cnt [2];
  bit              mdl_err;

  task automatic check(input string tag, input logic [R_W-1:0] got, input logic [R_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_valid  = 1'b0;
    mdl_id     = '0;
    mdl_ar     = '0;
    mdl_fav    = 0;
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;
    mdl_err    = 1'b0;
  endtask

  function automatic logic [R_W-1:0] rand_r(input bit last);
    logic [R_W-1:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) v = {v[R_W-33:0], 32'($urandom)};
    v[258] = last;
    return v;
  endfunction

  function automatic logic [AR_W-1:0] rand_ar();
    return AR_W'({$urandom, $urandom});
  endfunction

  task automatic idle_inputs();
    s0_arvalid = 0; s1_arvalid = 0; m_rvalid = 0;
    s0_rready = 0; s1_rready = 0; m_arready = 0;
    m_rid = '0; m_r = '0;
  endtask

  task automatic set_r(input bit vld, input logic [6:0] rid, input bit last, input bit r0, input bit r1);
    m_rvalid = vld; m_rid = rid; m_r = rand_r(last);
    s0_rready = r0; s1_rready = r1;
  endtask

  // One clock: compare at the falling edge, advance the model, return at posedge+1
  task automatic step();
    bit av [2];
    bit elig [2];
    bit rdy [2];
    bit acc [2];
    bit free;
    int win;
    int sel;
    bit hs, last, dec;
    logic [5:0]      ids [2];
    logic [AR_W-1:0] ars [2];
    @(negedge axi_clk);
    av[0] = s0_arvalid; av[1] = s1_arvalid;
    ids[0] = s0_arid;   ids[1] = s1_arid;
    ars[0] = s0_ar;     ars[1] = s1_ar;
    for (int x = 0; x < 2; x++) elig[x] = av[x] && (mdl_cnt[x] < MAX_OUTST);
    if (elig[0] && elig[1]) win = mdl_fav;
    else if (elig[0])       win = 0;
    else if (elig[1])       win = 1;
    else                    win = -1;
    free = !mdl_valid || m_arready;
    for (int x = 0; x < 2; x++) begin
      rdy[x] = free && (win == x);
      acc[x] = rdy[x] && av[x];
    end
    sel  = int'(m_rid[6]);
    check("s0_arready", R_W'(s0_arready), R_W'(rdy[0]));
    check("s1_arready", R_W'(s1_arready), R_W'(rdy[1]));
    check("m_arvalid",  R_W'(m_arvalid),  R_W'(mdl_valid));
    check("m_arid",     R_W'(m_arid),     R_W'(mdl_id));
    check("m_ar",       R_W'(m_ar),       R_W'(mdl_ar));
    check("outst0",     R_W'(outst0),     R_W'(mdl_cnt[0]));
    check("outst1",     R_W'(outst1),     R_W'(mdl_cnt[1]));
    check("rsp_err",    R_W'(rsp_err),    R_W'(mdl_err));
    check("s0_rvalid",  R_W'(s0_rvalid),  R_W'(m_rvalid && sel == 0));
    check("s1_rvalid",  R_W'(s1_rvalid),  R_W'(m_rvalid && sel == 1));
    check("m_rready",   R_W'(m_rready),   R_W'(sel == 1 ? s1_rready : s0_rready));
    check("s0_rid",     R_W'(s0_rid),     R_W'(m_rid[5:0]));
    check("s1_rid",     R_W'(s1_rid),     R_W'(m_rid[5:0]));
    check("s0_r",       s0_r,             m_r);
    check("s1_r",       s1_r,             m_r);
    // next state
    if (acc[0] || acc[1]) begin
      int w;
      w = acc[0] ? 0 : 1;
      mdl_valid = 1'b1;
      mdl_id    = {w[0], ids[w]};
      mdl_ar    = ars[w];
      mdl_fav   = 1 - w;
    end else if (m_arready) begin
      mdl_valid = 1'b0;
    end
    hs   = m_rvalid && (sel == 1 ? s1_rready : s0_rready);
    last = m_r[258];
    for (int x = 0; x < 2; x++) begin
      dec = hs && last && (sel == x);
      if (dec && mdl_cnt[x] == 0) mdl_err = 1'b1;
      mdl_cnt[x] = mdl_cnt[x] + (acc[x] ? 1 : 0) - ((dec && mdl_cnt[x] > 0) ? 1 : 0);
    end
    @(posedge axi_clk);
    #1;
  endtask

  // Asynchronous reset taken mid-cycle; returns at posedge+1 with reset released
  task automatic do_reset();
    #1 axi_reset_n = 1'b0;
    #1;
    check("rst_m_arvalid", R_W'(m_arvalid), '0);
    check("rst_m_arid",    R_W'(m_arid),    '0);
    check("rst_m_ar",      R_W'(m_ar),      '0);
    check("rst_outst0",    R_W'(outst0),    '0);
    check("rst_outst1",    R_W'(outst1),    '0);
    check("rst_rsp_err",   R_W'(rsp_err),   '0);
    idle_inputs();
    model_reset();
    @(posedge axi_clk);
    #1 axi_reset_n = 1'b1;
  endtask

  initial begin
    axi_reset_n = 1'b0;
    idle_inputs();
    s0_arid = '0; s1_arid = '0; s0_ar = '0; s1_ar = '0;
    model_reset();
    repeat (2) @(posedge axi_clk);
    #1;
    check("init_m_arvalid", R_W'(m_arvalid), '0);
    check("init_outst0",    R_W'(outst0),    '0);
    check("init_rsp_err",   R_W'(rsp_err),   '0);
    axi_reset_n = 1'b1;

    // Both requesters streaming with the slave always ready
    s0_arvalid = 1; s0_arid = 6'h05; s1_arvalid = 1; s1_arid = 6'h0A; m_arready = 1;
    for (int i = 0; i < 6; i++) begin
      s0_ar = rand_ar(); s1_ar = rand_ar();
      step();
      if (i == 0) check("rr_first",  R_W'(m_arid), R_W'(7'h05));
      if (i == 1) check("rr_second", R_W'(m_arid), R_W'(7'h4A));
    end

    // Slave stalls for five cycles while s0 keeps requesting
    s1_arvalid = 0; m_arready = 0;
    repeat (5) step();
    m_arready = 1;
    step();
    s0_arvalid = 0;
    step();

    // Fill s0 to the outstanding limit, then let s1 through and retire one s0 burst
    do_reset();
    s0_arvalid = 1; s0_arid = 6'h11; m_arready = 1;
    for (int i = 0; i < 18; i++) begin
      s0_ar = rand_ar();
      step();
    end
    check("full_outst0",  R_W'(outst0),     R_W'(16));
    check("full_s0_ardy", R_W'(s0_arready), '0);
    s1_arvalid = 1; s1_arid = 6'h22;
    step();
    s1_arvalid = 0;
    set_r(1, 7'h03, 1, 1, 0);
    step();
    set_r(0, 7'h00, 0, 0, 0);
    check("retire_outst0", R_W'(outst0), R_W'(15));
    step();
    s0_arvalid = 0;
    step();

    // Four-beat s1 burst with s1 back-pressure between beats
    for (int b = 0; b < 4; b++) begin
      set_r(1, 7'h45, b == 3, 1, 0);
      step();
      set_r(1, 7'h45, b == 3, 0, 1);
      step();
    end
    set_r(0, 7'h00, 0, 0, 0);
    step();
    check("burst_outst1", R_W'(outst1), '0);

    // Last beat for s0 with nothing outstanding
    do_reset();
    set_r(1, 7'h00, 1, 1, 1);
    step();
    set_r(0, 7'h00, 0, 0, 0);
    repeat (3) step();
    check("err_sticky", R_W'(rsp_err), R_W'(1));

    // Same-cycle s1 accept and s1 last beat
    m_arready = 1; s1_arvalid = 1; s1_arid = 6'h07; s1_ar = rand_ar();
    step();
    set_r(1, 7'h47, 1, 0, 1);
    step();
    s1_arvalid = 0; set_r(0, 7'h00, 0, 0, 0);
    step();
    check("same_cycle_outst1", R_W'(outst1), R_W'(1));

    // Randomized traffic in chunks of varying load, reset between chunks
    for (int c = 0; c < 6; c++) begin
      int ar_pct, last_pct;
      do_reset();
      ar_pct   = (c % 2 == 0) ? 90 : 50;
      last_pct = (c % 3 == 0) ? 10 : 50;
      for (int i = 0; i < 300; i++) begin
        s0_arvalid = ($urandom_range(99) < ar_pct);
        s1_arvalid = ($urandom_range(99) < ar_pct);
        s0_arid = 6'($urandom); s1_arid = 6'($urandom);
        s0_ar = rand_ar(); s1_ar = rand_ar();
        m_arready = ($urandom_range(3) != 0);
        set_r($urandom_range(1) == 1, 7'($urandom), $urandom_range(99) < last_pct,
              $urandom_range(3) != 0, $urandom_range(3) != 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
